// File: rtl/param_sweep_counter.sv
// Modulo counter with up/down/Gray modes, synchronous load and a one-shot 0..MOD-1 sweep FSM.
// count/tc/busy/done update one edge after load/sweep_start/step; wraps follows tc by one cycle.
module param_sweep_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sweep_start,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] code,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wraps
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_wraps;

  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_load_clamped;

  // Wrap by explicit compare so a non-power-of-2 MOD never reaches codes >= MOD.
  assign w_at_max       = (r_count == MAX);
  assign w_at_zero      = (r_count == '0);
  assign w_inc          = w_at_max  ? '0  : r_count + WIDTH'(1);
  assign w_dec          = w_at_zero ? MAX : r_count - WIDTH'(1);
  assign w_load_clamped = (load_val > MAX) ? MAX : load_val;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wraps <= 8'd0;
    end else begin
      r_tc <= 1'b0;
      if (r_tc && (r_wraps != 8'hFF)) begin
        r_wraps <= r_wraps + 8'd1;
      end

      if (load) begin
        r_count <= w_load_clamped;
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (sweep_start && (r_state != S_RUN)) begin
        r_count <= '0;
        r_state <= S_RUN;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else if (r_state == S_RUN) begin
        // Sweep ignores en and mode; the final step lands on 0 with tc and ends the run.
        r_count <= w_inc;
        if (w_at_max) begin
          r_tc    <= 1'b1;
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else if (en) begin
        case (mode)
          2'b00, 2'b10: begin
            r_count <= w_inc;
            r_tc    <= w_at_max;
          end
          2'b01: begin
            r_count <= w_dec;
            r_tc    <= w_at_zero;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Gray wrap for non-power-of-2 MOD is multi-bit; that is accepted as-is.
  assign code  = (mode == 2'b10) ? (r_count ^ (r_count >> 1)) : r_count;
  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = r_busy;
  assign done  = r_done;
  assign wraps = r_wraps;

endmodule

// File: tb/tb_param_sweep_counter.sv
// Directed bench for param_sweep_counter across MOD=8, 10, 16 and 2 instances.
module tb_param_sweep_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Modulus 8 instance (defaults)
  logic       d_en = 0, d_load = 0, d_ss = 0;
  logic [1:0] d_mode = 2'b00;
  logic [3:0] d_lv = 0, d_count, d_code;
  logic       d_tc, d_busy, d_done;
  logic [7:0] d_wraps;
  // Modulus 10 instance
  logic       a_en = 0, a_load = 0, a_ss = 0;
  logic [1:0] a_mode = 2'b00;
  logic [3:0] a_lv = 0, a_count, a_code;
  logic       a_tc, a_busy, a_done;
  logic [7:0] a_wraps;
  // Modulus 16 instance
  logic       g_en = 0, g_load = 0, g_ss = 0;
  logic [1:0] g_mode = 2'b00;
  logic [3:0] g_lv = 0, g_count, g_code;
  logic       g_tc, g_busy, g_done;
  logic [7:0] g_wraps;
  // Modulus 2 instance
  logic       t_en = 0, t_load = 0, t_ss = 0;
  logic [1:0] t_mode = 2'b00;
  logic [3:0] t_lv = 0, t_count, t_code;
  logic       t_tc, t_busy, t_done;
  logic [7:0] t_wraps;

  param_sweep_counter #(.WIDTH(4), .MOD(8)) u_d (
    .CLK(clk), .RST(rst), .en(d_en), .mode(d_mode), .load(d_load), .load_val(d_lv),
    .sweep_start(d_ss), .count(d_count), .code(d_code), .tc(d_tc), .busy(d_busy),
    .done(d_done), .wraps(d_wraps));
  param_sweep_counter #(.WIDTH(4), .MOD(10)) u_a (
    .CLK(clk), .RST(rst), .en(a_en), .mode(a_mode), .load(a_load), .load_val(a_lv),
    .sweep_start(a_ss), .count(a_count), .code(a_code), .tc(a_tc), .busy(a_busy),
    .done(a_done), .wraps(a_wraps));
  param_sweep_counter #(.WIDTH(4), .MOD(16)) u_g (
    .CLK(clk), .RST(rst), .en(g_en), .mode(g_mode), .load(g_load), .load_val(g_lv),
    .sweep_start(g_ss), .count(g_count), .code(g_code), .tc(g_tc), .busy(g_busy),
    .done(g_done), .wraps(g_wraps));
  param_sweep_counter #(.WIDTH(4), .MOD(2)) u_t (
    .CLK(clk), .RST(rst), .en(t_en), .mode(t_mode), .load(t_load), .load_val(t_lv),
    .sweep_start(t_ss), .count(t_count), .code(t_code), .tc(t_tc), .busy(t_busy),
    .done(t_done), .wraps(t_wraps));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] gray_exp [16];
    logic [3:0] prev_code;
    int         seen_tc;
    int         exp_w;

    gray_exp = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    // Reset values while RST is held
    #2;
    chk("rst_count", d_count, 0);
    chk("rst_tc", d_tc, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_done", d_done, 0);
    chk("rst_wraps", d_wraps, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_count", d_count, 0);

    // Modulus 8 sweep: 0..7 with busy, then 0 with tc and done, wraps one cycle later
    d_ss = 1'b1;
    tick();
    d_ss = 1'b0;
    chk("sw_count0", d_count, 0);
    chk("sw_busy0", d_busy, 1);
    for (int i = 1; i < 8; i++) begin
      if (i == 3) d_ss = 1'b1;
      tick();
      d_ss = 1'b0;
      chk("sw_count", d_count, i);
      chk("sw_busy", d_busy, 1);
      chk("sw_tc_low", d_tc, 0);
    end
    tick();
    chk("sw_end_count", d_count, 0);
    chk("sw_end_tc", d_tc, 1);
    chk("sw_end_done", d_done, 1);
    chk("sw_end_busy", d_busy, 0);
    chk("sw_end_wraps_lag", d_wraps, 0);
    d_en = 1'b1;
    tick();
    d_en = 1'b0;
    chk("sw_wraps", d_wraps, 1);
    chk("sw_tc_clear", d_tc, 0);
    chk("done_free_count", d_count, 1);
    chk("done_persist", d_done, 1);

    // Modulus 10 down from 0 wraps to 9 with tc
    a_en = 1'b1;
    a_mode = 2'b01;
    tick();
    chk("dn_wrap_count", a_count, 9);
    chk("dn_wrap_tc", a_tc, 1);
    tick();
    chk("dn_count8", a_count, 8);
    chk("dn_tc_low", a_tc, 0);
    chk("dn_wraps", a_wraps, 1);
    tick();
    chk("dn_count7", a_count, 7);
    a_en = 1'b0;
    tick();
    chk("en0_hold", a_count, 7);
    a_en = 1'b1;
    a_mode = 2'b11;
    tick();
    chk("mode11_hold", a_count, 7);
    chk("mode11_tc", a_tc, 0);
    chk("mode11_code", a_code, 7);

    // Load clamps to MOD-1; up from 9 wraps to 0
    a_en = 1'b0;
    a_load = 1'b1;
    a_lv = 4'd13;
    tick();
    a_load = 1'b0;
    chk("load_clamp", a_count, 9);
    chk("load_tc", a_tc, 0);
    a_en = 1'b1;
    a_mode = 2'b00;
    tick();
    a_en = 1'b0;
    chk("up_wrap_count", a_count, 0);
    chk("up_wrap_tc", a_tc, 1);

    // load wins over sweep_start on the same edge
    a_load = 1'b1;
    a_ss = 1'b1;
    a_lv = 4'd5;
    tick();
    a_load = 1'b0;
    a_ss = 1'b0;
    chk("ld_ss_count", a_count, 5);
    chk("ld_ss_busy", a_busy, 0);
    chk("ld_ss_done", a_done, 0);

    // load during RUN aborts the sweep
    a_ss = 1'b1;
    tick();
    a_ss = 1'b0;
    chk("run_busy", a_busy, 1);
    chk("run_count0", a_count, 0);
    tick();
    tick();
    chk("run_count2", a_count, 2);
    a_load = 1'b1;
    a_lv = 4'd3;
    tick();
    a_load = 1'b0;
    chk("abort_count", a_count, 3);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    tick();
    chk("abort_stays_idle", a_busy, 0);
    chk("abort_count_hold", a_count, 3);

    // Modulus 16 Gray sweep, single-bit change on every step
    g_mode = 2'b10;
    #0;
    chk("gray_start", g_code, 0);
    g_en = 1'b1;
    prev_code = g_code;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("gray_code", g_code, gray_exp[(i + 1) % 16]);
      chk("gray_onebit", $countones(g_code ^ prev_code), 1);
      chk("gray_tc", g_tc, (i == 15) ? 1 : 0);
      prev_code = g_code;
    end
    g_en = 1'b0;

    // RST mid-sweep between edges
    d_ss = 1'b1;
    tick();
    d_ss = 1'b0;
    tick();
    tick();
    chk("pre_rst_count", d_count, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", d_count, 0);
    chk("mid_rst_busy", d_busy, 0);
    chk("mid_rst_done", d_done, 0);
    chk("mid_rst_tc", d_tc, 0);
    chk("mid_rst_wraps", d_wraps, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("after_rst_busy", d_busy, 0);
    chk("after_rst_done", d_done, 0);
    chk("after_rst_count", d_count, 0);

    // Modulus 2 free-running up: tc every other cycle, wraps saturates
    t_en = 1'b1;
    seen_tc = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      chk("m2_tc", t_tc, (i % 2 == 1) ? 1 : 0);
      exp_w = (seen_tc > 255) ? 255 : seen_tc;
      chk("m2_wraps", t_wraps, exp_w);
      if (i % 2 == 1) seen_tc++;
    end
    tick();
    chk("m2_wraps_sat", t_wraps, 255);
    t_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
